// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit:
// DMType codes, FSM encoding and size/sign helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  localparam logic [1:0] WDSEL_MEM = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } mau_state_e;

  function automatic logic dm_is_byte(
    input logic [2:0] t
  );
    return (t == DM_BYTE) || (t == DM_BYTEU);
  endfunction

  function automatic logic dm_is_half(
    input logic [2:0] t
  );
    return (t == DM_HALF) || (t == DM_HALFU);
  endfunction

  function automatic logic dm_is_signed(
    input logic [2:0] t
  );
    return (t == DM_BYTE) || (t == DM_HALF);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed data bus with a req/ack handshake.
// The access unit is the master, memory is the slave.
interface mem_access_unit_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req,
    output we,
    output addr,
    output be,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  be,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/mem_access_unit_dm_align.sv
// Store lane steering, alignment check and load
// extension for the data memory bus.
module dm_align (
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_type,
  input  logic [31:0] rd2,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        aligned,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_type,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  import mem_access_unit_pkg::*;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sgn;

  always_comb begin
    be      = 4'b1111;
    wdata   = rd2;
    aligned = (st_off == 2'b00);
    unique case (1'b1)
      dm_is_byte(st_type): begin
        be      = 4'b0001 << st_off;
        wdata   = {4{rd2[7:0]}};
        aligned = 1'b1;
      end
      dm_is_half(st_type): begin
        be      = st_off[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{rd2[15:0]}};
        aligned = ~st_off[0];
      end
      default: ;
    endcase
  end

  assign ld_byte = rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = rdata[{ld_off[1], 4'b0000} +: 16];
  assign ld_sgn  = dm_is_signed(ld_type);

  always_comb begin
    ld_data = rdata;
    unique case (1'b1)
      dm_is_byte(ld_type):
        ld_data = {{24{ld_sgn & ld_byte[7]}}, ld_byte};
      dm_is_half(ld_type):
        ld_data = {{16{ld_sgn & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ME-stage data access controller: issues one bus
// transaction per load/store and stalls until it completes.
module mem_access_unit (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      me_MemWrite,
  input  logic                      me_MemRead,
  input  logic [2:0]                me_DMType,
  input  logic [31:0]               me_aluout,
  input  logic [31:0]               me_RD2,
  mem_access_unit_if.master         bus,
  output logic                      mem_stall,
  output logic [31:0]               load_data,
  output logic                      misalign
);
  import mem_access_unit_pkg::*;

  mau_state_e  state;
  logic [1:0]  cap_off;
  logic [2:0]  cap_type;
  logic        cap_read;

  logic        access;
  logic        aligned;
  logic        issue;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;

  dm_align u_align (
    .st_off  (me_aluout[1:0]),
    .st_type (me_DMType),
    .rd2     (me_RD2),
    .be      (st_be),
    .wdata   (st_wdata),
    .aligned (aligned),
    .ld_off  (cap_off),
    .ld_type (cap_type),
    .rdata   (bus.rdata),
    .ld_data (ld_ext)
  );

  assign access = me_MemRead | me_MemWrite;
  assign issue  = (state == S_IDLE) & access & aligned;

  // Gated by rst_n so the pipeline is never held during reset.
  assign mem_stall = rst_n & (issue | (state == S_WAIT));
  assign misalign  = rst_n & (state == S_IDLE)
                   & access & ~aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.be    <= '0;
      bus.wdata <= '0;
      load_data <= '0;
      cap_off   <= '0;
      cap_type  <= '0;
      cap_read  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            bus.req   <= 1'b1;
            bus.we    <= me_MemWrite;
            bus.addr  <= {me_aluout[31:2], 2'b00};
            bus.be    <= st_be;
            bus.wdata <= st_wdata;
            cap_off   <= me_aluout[1:0];
            cap_type  <= me_DMType;
            cap_read  <= ~me_MemWrite;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.ack) begin
            bus.req <= 1'b0;
            bus.we  <= 1'b0;
            if (cap_read)
              load_data <= ld_ext;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table
// plus hand-written misalign and reset sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        me_MemWrite = 1'b0;
  logic        me_MemRead = 1'b0;
  logic [2:0]  me_DMType = 3'b000;
  logic [31:0] me_aluout = '0;
  logic [31:0] me_RD2 = '0;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .me_MemWrite (me_MemWrite),
    .me_MemRead  (me_MemRead),
    .me_DMType   (me_DMType),
    .me_aluout   (me_aluout),
    .me_RD2      (me_RD2),
    .bus         (bus),
    .mem_stall   (mem_stall),
    .load_data   (load_data),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  dt;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    int          ack_n;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_baddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    int          exp_stall;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h",
               name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    me_MemWrite = 1'b0;
    me_MemRead  = 1'b0;
    me_DMType   = DM_WORD;
    me_aluout   = '0;
    me_RD2      = '0;
  endtask

  // Entered and left at posedge+1; no gap between calls.
  task automatic do_access(input int idx, input vec_t v);
    int  stall_cnt;
    bit  done;
    bit  hold_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    me_MemWrite = v.we;
    me_MemRead  = v.re;
    me_DMType   = v.dt;
    me_aluout   = v.addr;
    me_RD2      = v.rd2;
    bus.rdata   = v.rdata;
    stall_cnt = 0;
    done      = 1'b0;
    hold_ok   = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, " req"}, 32'(bus.req), 32'd1);
        chk({tag, " we"}, 32'(bus.we), 32'(v.exp_we));
        chk({tag, " addr"}, bus.addr, v.exp_baddr);
        chk({tag, " be"}, 32'(bus.be), 32'(v.exp_be));
        chk({tag, " wdata"}, bus.wdata, v.exp_wdata);
      end
      if (c >= 1 && mem_stall &&
          (bus.req !== 1'b1 || bus.addr !== v.exp_baddr))
        hold_ok = 1'b0;
      if (mem_stall)
        stall_cnt++;
      else begin
        done = 1'b1;
        chk({tag, " load"}, load_data, v.exp_load);
        chk({tag, " req_done"}, 32'(bus.req), 32'd0);
      end
      bus.ack = (c == v.ack_n);
      @(posedge clk);
      #1;
      bus.ack = 1'b0;
    end
    chk({tag, " finished"}, 32'(done), 32'd1);
    chk({tag, " stall"}, stall_cnt, v.exp_stall);
    chk({tag, " hold"}, 32'(hold_ok), 32'd1);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, 0, DM_WORD, 32'h104, 32'hDEADBEEF,
                 32'h0, 3, 1, 4'hF, 32'h104,
                 32'hDEADBEEF, 32'h0, 4};
    vecs[1]  = '{0, 1, DM_BYTE, 32'h203, 32'h0,
                 32'h80123456, 1, 0, 4'h8, 32'h200,
                 32'h0, 32'hFFFFFF80, 2};
    vecs[2]  = '{0, 1, DM_BYTEU, 32'h203, 32'h0,
                 32'h80123456, 2, 0, 4'h8, 32'h200,
                 32'h0, 32'h00000080, 3};
    vecs[3]  = '{0, 1, DM_HALF, 32'h202, 32'h0,
                 32'h80017FFF, 1, 0, 4'hC, 32'h200,
                 32'h0, 32'hFFFF8001, 2};
    vecs[4]  = '{0, 1, DM_HALFU, 32'h202, 32'h0,
                 32'h80017FFF, 4, 0, 4'hC, 32'h200,
                 32'h0, 32'h00008001, 5};
    vecs[5]  = '{1, 0, DM_BYTE, 32'h101, 32'h000000AB,
                 32'h0, 1, 1, 4'h2, 32'h100,
                 32'hABABABAB, 32'h00008001, 2};
    vecs[6]  = '{1, 0, DM_HALF, 32'h102, 32'h1234CAFE,
                 32'h0, 2, 1, 4'hC, 32'h100,
                 32'hCAFECAFE, 32'h00008001, 3};
    vecs[7]  = '{0, 1, DM_WORD, 32'h108, 32'h0,
                 32'h12345678, 1, 0, 4'hF, 32'h108,
                 32'h0, 32'h12345678, 2};
    vecs[8]  = '{0, 1, DM_BYTE, 32'h200, 32'h0,
                 32'h0000007F, 1, 0, 4'h1, 32'h200,
                 32'h0, 32'h0000007F, 2};
    vecs[9]  = '{1, 1, DM_WORD, 32'h10, 32'h55AA55AA,
                 32'hFFFFFFFF, 1, 1, 4'hF, 32'h10,
                 32'h55AA55AA, 32'h0000007F, 2};
    vecs[10] = '{0, 1, 3'b101, 32'h20, 32'h0,
                 32'hA5A50F0F, 1, 0, 4'hF, 32'h20,
                 32'h0, 32'hA5A50F0F, 2};
    vecs[11] = '{0, 1, DM_HALF, 32'h200, 32'h0,
                 32'h00008000, 1, 0, 4'h3, 32'h200,
                 32'h0, 32'hFFFF8000, 2};
    vecs[12] = '{0, 1, DM_BYTEU, 32'h201, 32'h0,
                 32'h0000FF00, 2, 0, 4'h2, 32'h200,
                 32'h0, 32'h000000FF, 3};

    bus.ack   = 1'b0;
    bus.rdata = '0;

    // Reset state, with a live request on the inputs.
    me_MemRead = 1'b1;
    me_aluout  = 32'h1;
    #12;
    chk("rst stall", 32'(mem_stall), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst req", 32'(bus.req), 32'd0);
    chk("rst we", 32'(bus.we), 32'd0);
    chk("rst addr", bus.addr, 32'h0);
    chk("rst be", 32'(bus.be), 32'h0);
    chk("rst wdata", bus.wdata, 32'h0);
    chk("rst load", load_data, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++)
      do_access(i, vecs[i]);

    // Misaligned accesses are dropped without stalling.
    me_MemRead = 1'b1;
    me_DMType  = DM_WORD;
    me_aluout  = 32'h106;
    bus.ack    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mis lw flag", 32'(misalign), 32'd1);
      chk("mis lw stall", 32'(mem_stall), 32'd0);
      chk("mis lw req", 32'(bus.req), 32'd0);
    end
    chk("mis lw load", load_data, 32'h000000FF);
    me_DMType = DM_HALF;
    me_aluout = 32'h203;
    #1;
    chk("mis lh flag", 32'(misalign), 32'd1);
    me_DMType = DM_BYTE;
    #1;
    chk("lb 203 flag", 32'(misalign), 32'd0);
    idle_inputs();

    // A stray ack while idle must not start anything.
    @(negedge clk);
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    @(negedge clk);
    chk("idle ack req", 32'(bus.req), 32'd0);
    chk("idle ack stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;

    // Reset during WAIT abandons the transaction.
    me_MemWrite = 1'b1;
    me_DMType   = DM_WORD;
    me_aluout   = 32'h40;
    me_RD2      = 32'h11111111;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wait req", 32'(bus.req), 32'd1);
    chk("wait stall", 32'(mem_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst req", 32'(bus.req), 32'd0);
    chk("arst stall", 32'(mem_stall), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_access(13, '{1, 0, DM_WORD, 32'h10, 32'hCAFEBABE,
                    32'h0, 1, 1, 4'hF, 32'h10,
                    32'hCAFEBABE, 32'h0, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
